pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers (e.g. MEM/WB).
- Carries a generic payload of DATA_W data bits and CTRL_W control bits between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so downstream stalls never combinationally reach upstream.
- Supports synchronous flush (bubble insertion) and forces control bits to zero on bubbles, so a killed slot can never assert RegWrite/MemToReg downstream.

Parameters:
DATA_W, 32, width of data payload (ALU result / read data concatenated by instantiator)
CTRL_W, 7, width of control payload (write-reg index + control strobes)
CTRL_RST, 0, reset/bubble value driven on out_ctrl when out_valid=0 (CTRL_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  block can accept; registered, no combinational path from out_ready
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main-entry data
out_ctrl  out  CTRL_W  main-entry control, gated: CTRL_RST when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Handshake fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry.
- Reset (rst=0, asynchronous), all outputs:
  - state EMPTY; out_valid=0, in_ready=1, occupancy=0.
  - main/skid data and ctrl = 0; out_data=0, out_ctrl=CTRL_RST.
- State EMPTY (occ 0, in_ready=1, out_valid=0):
  - in_fire: main<=in -> ONE.
- State ONE (occ 1, in_ready=1, out_valid=1):
  - in_fire & out_fire: main<=in, stay ONE.
  - in_fire only: skid<=in -> FULL.
  - out_fire only: -> EMPTY.
  - neither: hold.
- State FULL (occ 2, in_ready=0, out_valid=1):
  - out_fire: main<=skid -> ONE.
  - otherwise hold; in_valid ignored.
- Latency: payload accepted at edge N appears on out_* after edge N (1 cycle) when the block was EMPTY or ONE with out_fire.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Ordering is strictly FIFO; no beat is dropped or duplicated except by flush.
- Flush (synchronous, sampled at rising edge, highest priority):
  - next state EMPTY, regardless of in_fire/out_fire in the same cycle.
  - A beat presented with in_fire in the flush cycle is discarded.
  - Data registers keep their old contents (don't-care); out_ctrl reads CTRL_RST because out_valid=0.
- out_ctrl is a combinational gate of main_ctrl by out_valid; out_data is not gated.
- in_ready and out_valid depend only on state registers.
- rst asserted mid-transfer: outputs take reset values immediately (asynchronously); pending beats are lost.
- in_data/in_ctrl are don't-care when in_valid=0; the block must not capture them.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and beat_cnt[31:0].
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - beat_cnt increments on each out_fire.
  - Both wrap modulo 2^32, reset to 0 by rst only (flush does not clear them).
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Reset: rst=0 with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, out_ctrl=0, in_ready=1, occupancy=0. Release rst -> still empty until an in_fire.
- Streaming: out_ready=1, send A5A5A5A5/ctrl 7'h35 then 12345678/ctrl 7'h0A on consecutive cycles -> each appears on out_* exactly 1 cycle later in order; occupancy stays 1.
- Skid: occupancy 1 holding 0x11; out_ready=0, push 0x22 -> occupancy=2, in_ready=0 next cycle; push 0x33 held -> not accepted. out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, none lost or duplicated.
- Flush: FULL with 0x44/0x55, flush=1 with in_valid=1 (0x66) and out_ready=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x66 never appears.
- Bubble gating: CTRL_RST=0, main_ctrl=7'h7F, then drain to EMPTY -> out_ctrl=0 while out_valid=0.
- Stats (PIPE_STAGE_STATS_EN): 3 stall cycles then 4 beats -> stall_cnt=3, beat_cnt=4; then flush -> counts unchanged; rst=0 -> both 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush and bubble-gated control.
// Optional PIPE_STAGE_STATS_EN adds stall_cnt/beat_cnt performance counters.
module pipe_stage_skid #(
   parameter int                DATA_W   = 32,
   parameter int                CTRL_W   = 7,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       beat_cnt,
`endif
   output logic [1:0]        occupancy
);

   // Encoding equals the number of held entries.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state, w_nxt;
   logic [DATA_W-1:0] r_main_data, r_skid_data;
   logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
   logic              w_in_fire, w_out_fire;
   logic              w_ld_main_in, w_ld_main_skid, w_ld_skid;

   assign in_ready   = (r_state != S_FULL);
   assign out_valid  = (r_state != S_EMPTY);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_comb begin
      w_nxt          = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_in_fire) begin
               w_ld_main_in = 1'b1;
               w_nxt        = S_ONE;
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_ld_main_in = 1'b1;
               end else if (w_in_fire) begin
                  w_ld_skid = 1'b1;
                  w_nxt     = S_FULL;
               end else if (w_out_fire) begin
                  w_nxt = S_EMPTY;
               end
            end
            S_FULL: if (w_out_fire) begin
               w_ld_main_skid = 1'b1;
               w_nxt          = S_ONE;
            end
            default: w_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_EMPTY;
      else      r_state <= w_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end else if (w_ld_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_ld_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end

   // Bubbles must never leak stale control strobes downstream.
   assign out_data  = r_main_data;
   assign out_ctrl  = out_valid ? r_main_ctrl : CTRL_RST;
   assign occupancy = r_state;

`ifdef PIPE_STAGE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         beat_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
         if (w_out_fire)              beat_cnt  <= beat_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid, flush, bubble gating, stats.
module tb_pipe_stage_skid;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 7;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, out_ready;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]       stall_cnt, beat_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(7'h00)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cnt(stall_cnt), .beat_cnt(beat_cnt),
`endif
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'hDEADBEEF, 7'h55);
      #1 rst = 1'b0;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ctrl", out_ctrl, 0);
      tick();
      chk("rst_hold_occ", occupancy, 0);
      chk("rst_hold_data", out_data, 0);
      drive(1'b0, 32'hBAD0BAD0, 7'h7F);
      rst = 1'b1;
      tick();
      chk("post_rst_occ", occupancy, 0);
      chk("post_rst_valid", out_valid, 0);

      // Streaming
      out_ready = 1'b1;
      drive(1'b1, 32'hA5A5A5A5, 7'h35);
      tick();
      chk("s1_valid", out_valid, 1);
      chk("s1_data", out_data, 32'hA5A5A5A5);
      chk("s1_ctrl", out_ctrl, 7'h35);
      chk("s1_occ", occupancy, 1);
      drive(1'b1, 32'h12345678, 7'h0A);
      tick();
      chk("s2_data", out_data, 32'h12345678);
      chk("s2_ctrl", out_ctrl, 7'h0A);
      chk("s2_occ", occupancy, 1);
      drive(1'b0, 32'hFFFFFFFF, 7'h7F);
      tick();
      chk("s3_occ", occupancy, 0);
      chk("s3_valid", out_valid, 0);

      // Skid
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 7'h01);
      tick();
      chk("k1_occ", occupancy, 1);
      chk("k1_data", out_data, 32'h11);
      drive(1'b1, 32'h22, 7'h02);
      tick();
      chk("k2_occ", occupancy, 2);
      chk("k2_ready", in_ready, 0);
      chk("k2_data", out_data, 32'h11);
      drive(1'b1, 32'h33, 7'h03);
      tick();
      chk("k3_occ", occupancy, 2);
      chk("k3_data", out_data, 32'h11);
      out_ready = 1'b1;
      tick();
      chk("k4_data", out_data, 32'h22);
      chk("k4_ctrl", out_ctrl, 7'h02);
      chk("k4_occ", occupancy, 1);
      chk("k4_ready", in_ready, 1);
      tick();
      chk("k5_data", out_data, 32'h33);
      chk("k5_ctrl", out_ctrl, 7'h03);
      chk("k5_occ", occupancy, 1);
      drive(1'b0, 32'h0, 7'h0);
      tick();
      chk("k6_occ", occupancy, 0);

      // Flush
      out_ready = 1'b0;
      drive(1'b1, 32'h44, 7'h04);
      tick();
      drive(1'b1, 32'h55, 7'h05);
      tick();
      chk("f0_occ", occupancy, 2);
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 32'h66, 7'h06);
      tick();
      chk("f1_valid", out_valid, 0);
      chk("f1_ctrl", out_ctrl, 0);
      chk("f1_occ", occupancy, 0);
      chk("f1_ready", in_ready, 1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 7'h0);
      tick();
      chk("f2_valid", out_valid, 0);
      chk("f2_occ", occupancy, 0);

      // Bubble gating: control forced low, data left visible
      out_ready = 1'b0;
      drive(1'b1, 32'h77, 7'h7F);
      tick();
      chk("b1_ctrl", out_ctrl, 7'h7F);
      drive(1'b0, 32'h0, 7'h0);
      out_ready = 1'b1;
      tick();
      chk("b2_valid", out_valid, 0);
      chk("b2_ctrl", out_ctrl, 0);
      chk("b2_data", out_data, 32'h77);

      // Stats window starts from a fresh reset
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b1, 32'h1, 7'h11);
      tick();
      drive(1'b0, 32'h0, 7'h0);
      tick(); tick(); tick();
`ifdef PIPE_STAGE_STATS_EN
      chk("st_stall3", stall_cnt, 3);
      chk("st_beat0", beat_cnt, 0);
`endif
      out_ready = 1'b1;
      drive(1'b1, 32'h2, 7'h12);
      tick();
      drive(1'b1, 32'h3, 7'h13);
      tick();
      drive(1'b1, 32'h4, 7'h14);
      tick();
      drive(1'b0, 32'h0, 7'h0);
      tick();
      chk("st_occ0", occupancy, 0);
`ifdef PIPE_STAGE_STATS_EN
      chk("st_stall", stall_cnt, 3);
      chk("st_beat", beat_cnt, 4);
`endif
      flush = 1'b1; out_ready = 1'b0;
      drive(1'b1, 32'h99, 7'h19);
      tick();
      flush = 1'b0;
      chk("st_flush_occ", occupancy, 0);
`ifdef PIPE_STAGE_STATS_EN
      chk("st_flush_stall", stall_cnt, 3);
      chk("st_flush_beat", beat_cnt, 4);
`endif

      // Asynchronous reset with a beat in flight
      drive(1'b1, 32'hABCD, 7'h2A);
      tick();
      chk("ar0_occ", occupancy, 1);
      rst = 1'b0;
      #2;
      chk("ar_valid", out_valid, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_data", out_data, 0);
      chk("ar_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_STATS_EN
      chk("ar_stall", stall_cnt, 0);
      chk("ar_beat", beat_cnt, 0);
`endif
      drive(1'b0, 32'h0, 7'h0);
      tick();
      rst = 1'b1;
      tick();
      chk("ar_after_occ", occupancy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
